// File: rtl/vedic_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vedic_div_pkg
// Description : Shared types and constants for the vedic_div_64 divider.
//               Holds the FSM state encoding, the default operand width and
//               the counter-width helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package vedic_div_pkg;

    localparam int DEFAULT_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Smallest r such that 2**r >= value (value >= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vedic_div_step.sv
`default_nettype none
// ============================================================================
// Module      : vedic_div_step
// Description : One purely combinational restoring-division iteration.
//               Shifts the next dividend bit into the partial remainder,
//               trial-subtracts the divisor and keeps the difference only
//               when it is non-negative.
// Ports       : i_pr      [W:0]   partial remainder in (always < divisor)
//               i_bit             next dividend bit
//               i_divisor [W-1:0] divisor
//               o_pr      [W:0]   partial remainder out
//               o_q               quotient bit produced by this iteration
// Revision    : 1.0 - initial release
// ============================================================================
module vedic_div_step
    import vedic_div_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W:0]   i_pr,
    input  logic         i_bit,
    input  logic [W-1:0] i_divisor,
    output logic [W:0]   o_pr,
    output logic         o_q
);

    // One extra bit of headroom so the MSB of the difference is a clean sign.
    logic [W+1:0] w_shift;
    logic [W+1:0] w_diff;

    assign w_shift = {i_pr, i_bit};
    assign w_diff  = w_shift - {2'b00, i_divisor};
    assign o_q     = ~w_diff[W+1];
    assign o_pr    = o_q ? w_diff[W:0] : w_shift[W:0];

endmodule
`default_nettype wire

// File: rtl/vedic_div_64.sv
`default_nettype none
// ============================================================================
// Module      : vedic_div_64
// Description : Sequential unsigned restoring divider, 2W-bit dividend by
//               W-bit divisor, producing W-bit quotient and remainder.
//               Valid/ready handshake on input and output.
//               Optional macro VEDIC_DIV_RADIX4_EN chains two restoring
//               steps per cycle (2 quotient bits per clock).
// Ports       : CLK, RST (async, active-high)
//               in_valid / in_ready           operand handshake
//               dividend [2W-1:0], divisor [W-1:0]
//               out_valid / out_ready         result handshake
//               quotient [W-1:0], remainder [W-1:0]
//               div_by_zero, overflow         error flags
//               busy                          state != IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module vedic_div_64
    import vedic_div_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow,
    output logic           busy
);

    localparam int C_CNT_W = clog2(W);
`ifdef VEDIC_DIV_RADIX4_EN
    localparam int C_ITERS = W / 2;
`else
    localparam int C_ITERS = W;
`endif
    localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(C_ITERS - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    state_t             r_state;
    logic [W:0]         r_pr;
    // Holds the unconsumed dividend bits at the top and collects quotient
    // bits at the bottom; after the last iteration it is the quotient.
    logic [W-1:0]       r_shift;
    logic [W-1:0]       r_divisor;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_dbz;
    logic               r_ovf;

    logic [W:0]         w_pr0;
    logic               w_q0;
    logic [W:0]         w_pr_next;
    logic [W-1:0]       w_shift_next;

    vedic_div_step #(.W(W)) u_step0 (
        .i_pr      (r_pr),
        .i_bit     (r_shift[W-1]),
        .i_divisor (r_divisor),
        .o_pr      (w_pr0),
        .o_q       (w_q0)
    );

`ifdef VEDIC_DIV_RADIX4_EN
    logic [W:0] w_pr1;
    logic       w_q1;

    vedic_div_step #(.W(W)) u_step1 (
        .i_pr      (w_pr0),
        .i_bit     (r_shift[W-2]),
        .i_divisor (r_divisor),
        .o_pr      (w_pr1),
        .o_q       (w_q1)
    );

    assign w_pr_next    = w_pr1;
    assign w_shift_next = {r_shift[W-3:0], w_q0, w_q1};
`else
    assign w_pr_next    = w_pr0;
    assign w_shift_next = {r_shift[W-2:0], w_q0};
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_pr        <= '0;
            r_shift     <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Partial remainder starts as the dividend high half.
                        r_pr       <= {1'b0, dividend[2*W-1:W]};
                        r_shift    <= dividend[W-1:0];
                        r_divisor  <= divisor;
                        r_dbz      <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= CHECK;
                    end
                end

                CHECK: begin
                    if (r_divisor == '0) begin
                        r_dbz       <= 1'b1;
                        r_pr        <= {1'b0, r_shift};
                        r_shift     <= '1;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_pr[W-1:0] >= r_divisor) begin
                        // High half >= divisor means the quotient needs > W bits.
                        r_ovf       <= 1'b1;
                        r_pr        <= {1'b0, r_shift};
                        r_shift     <= '1;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt   <= C_CNT_INIT;
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    r_pr    <= w_pr_next;
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt - C_CNT_ONE;
                    if (r_cnt == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign busy        = r_busy;
    assign quotient    = r_shift;
    assign remainder   = r_pr[W-1:0];
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule
`default_nettype wire
